// File: rtl/simd_unpack_pipe.sv
// Two-stage SIMD unpack/deinterleave pipeline: S1 captures the operands, S2 holds
// the permuted result. Both sides use a valid/ready handshake.
module simd_unpack_pipe #(
    parameter int SIMD_WIDTH = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIMD_WIDTH-1:0] A,
    input  logic [SIMD_WIDTH-1:0] B,
    input  logic [2:0]            data_mode,
    input  logic [1:0]            op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIMD_WIDTH-1:0] out,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  op_count
);
    typedef enum logic [1:0] {
        OP_UNPCKLO    = 2'd0,
        OP_UNPCKHI    = 2'd1,
        OP_DEINT_EVEN = 2'd2,
        OP_DEINT_ODD  = 2'd3
    } op_e;

    logic                  s1_valid;
    logic                  s2_valid;
    logic                  s1_adv;
    logic                  in_xfer;
    logic                  out_xfer;
    logic [SIMD_WIDTH-1:0] s1_a;
    logic [SIMD_WIDTH-1:0] s1_b;
    logic [2:0]            s1_mode;
    op_e                   s1_op;
    logic [SIMD_WIDTH-1:0] mode_res [8];
    logic [7:0]            mode_err;
    logic [SIMD_WIDTH-1:0] s1_res;
    logic                  s1_err;

    assign out_xfer  = s2_valid && out_ready;
    assign s1_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s1_adv;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = s2_valid;

    // One permutation network per element size; sizes wider than half the
    // vector cannot be paired, so those modes pass A through and flag an error.
    for (genvar m = 0; m < 8; m++) begin : g_mode
        localparam int ELEM = 8 << m;
        if (ELEM <= SIMD_WIDTH / 2) begin : g_legal
            localparam int NUM  = SIMD_WIDTH / ELEM;
            localparam int HNUM = NUM / 2;
            logic [2*SIMD_WIDTH-1:0] cat;
            logic [SIMD_WIDTH-1:0]   res;

            assign cat = {s1_a, s1_b};

            always_comb begin
                res = '0;
                case (s1_op)
                    OP_UNPCKLO: begin
                        for (int i = 0; i < HNUM; i++) begin
                            res[2*i*ELEM +: ELEM]     = s1_b[i*ELEM +: ELEM];
                            res[(2*i+1)*ELEM +: ELEM] = s1_a[i*ELEM +: ELEM];
                        end
                    end
                    OP_UNPCKHI: begin
                        for (int i = 0; i < HNUM; i++) begin
                            res[2*i*ELEM +: ELEM]     = s1_b[(HNUM+i)*ELEM +: ELEM];
                            res[(2*i+1)*ELEM +: ELEM] = s1_a[(HNUM+i)*ELEM +: ELEM];
                        end
                    end
                    OP_DEINT_EVEN: begin
                        for (int j = 0; j < NUM; j++) begin
                            res[j*ELEM +: ELEM] = cat[2*j*ELEM +: ELEM];
                        end
                    end
                    default: begin
                        for (int j = 0; j < NUM; j++) begin
                            res[j*ELEM +: ELEM] = cat[(2*j+1)*ELEM +: ELEM];
                        end
                    end
                endcase
            end

            assign mode_res[m] = res;
            assign mode_err[m] = 1'b0;
        end else begin : g_illegal
            assign mode_res[m] = s1_a;
            assign mode_err[m] = 1'b1;
        end
    end

    assign s1_res = mode_res[s1_mode];
    assign s1_err = mode_err[s1_mode];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= '0;
            s1_op    <= OP_UNPCKLO;
            out      <= '0;
            err      <= 1'b0;
            op_count <= '0;
        end else begin
            if (in_xfer) begin
                s1_a    <= A;
                s1_b    <= B;
                s1_mode <= data_mode;
                s1_op   <= op_e'(op);
            end

            if (in_xfer) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            // S2 only reloads when S1 moves forward, so a stalled result holds.
            if (s1_adv) begin
                out      <= s1_res;
                err      <= s1_err;
                s2_valid <= 1'b1;
            end else if (out_xfer) begin
                s2_valid <= 1'b0;
            end

            if (out_xfer && (op_count != '1)) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: doc/simd_unpack_pipe.md
SIMD_UNPACK_PIPE -- requirements
Module: simd_unpack_pipe

Interface
REQ-001 The block SHALL have parameter SIMD_WIDTH, default 256, giving operand/result width in bits; legal values are powers of two, 128..1024.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the completed-operation counter.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 in_valid  input  1  upstream presents an operation.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 A  input  SIMD_WIDTH  first operand.
REQ-008 B  input  SIMD_WIDTH  second operand.
REQ-009 data_mode  input  3  element size E = 8<<data_mode bits.
REQ-010 op  input  2  0=UNPCKLO, 1=UNPCKHI, 2=DEINT_EVEN, 3=DEINT_ODD.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 out  output  SIMD_WIDTH  result.
REQ-014 err  output  1  result came from an illegal data_mode; qualified by out_valid.
REQ-015 op_count  output  CNT_WIDTH  number of results consumed since reset, saturating.

Function
REQ-016 Transfers SHALL occur only on valid&&ready at a rising clk edge; A, B, data_mode, op are sampled only on an input transfer.
REQ-017 The pipeline SHALL have two register stages (S1 operand capture, S2 result); latency input transfer -> out_valid SHALL be exactly 2 cycles when unstalled.
REQ-018 S1 advances when S1 is full and (S2 empty or S2 consumed); in_ready SHALL equal !S1_valid || S1_advance, i.e. full throughput of 1 op/cycle with out_ready held high.
REQ-019 While out_valid=1 and out_ready=0, out and err SHALL hold stable; no operation SHALL be dropped or duplicated.
REQ-020 Element index i of X means X[(i+1)*E-1 -: E]; N = SIMD_WIDTH/E; H = N/2.
REQ-021 UNPCKLO: out element 2i = B element i, out element 2i+1 = A element i, for i in 0..H-1.
REQ-022 UNPCKHI: out element 2i = B element H+i, out element 2i+1 = A element H+i, for i in 0..H-1.
REQ-023 DEINT_EVEN: with C = {A,B} (B in low half, 2N elements), out element j = C element 2j, j in 0..N-1.
REQ-024 DEINT_ODD: out element j = C element 2j+1, j in 0..N-1.
REQ-025 data_mode is legal iff E <= SIMD_WIDTH/2; for illegal data_mode, out SHALL equal A and err SHALL be 1, for every op.
REQ-026 op_count SHALL increment by 1 on each output transfer and SHALL saturate at all-ones.
REQ-027 Simultaneous input transfer and output transfer in one cycle SHALL both complete.
REQ-028 Output SHALL be a pure function of the sampled fields; stall duration SHALL not affect results.

Reset
REQ-029 On a clk edge with rst_n=0, S1_valid, S2_valid, out_valid, err SHALL become 0, op_count 0, out all-zero; in_ready SHALL be 1 from the first cycle after reset.
REQ-030 Reset mid-operation SHALL discard all in-flight operations without producing an output transfer.

Verification
REQ-031 W=256, op=0, mode=0, A bytes=0xA0+i, B bytes=0xB0+i, out_ready=1 -> 2 cycles later out bytes low-to-high = B0,A0,B1,A1,...,BF,AF; err=0.
REQ-032 op=1, mode=4 -> out = {A[255:128], B[255:128]}; op=2, mode=4 -> out = {A[127:0], B[127:0]}; op=3, mode=4 -> out = {A[255:128], B[255:128]}.
REQ-033 mode=5 (E=256), any op -> out = A, err=1, op_count increments on consumption.
REQ-034 Back-to-back 8 ops with out_ready=1 -> 8 results on consecutive cycles, in order; then out_ready=0 for 5 cycles -> in_ready drops after two more accepts, out held stable, no loss on release.
REQ-035 Assert rst_n=0 with both stages full -> next cycle out_valid=0, op_count=0, no output transfer occurs.
REQ-036 CNT_WIDTH=4, 17 consumed results -> op_count=15, remains 15.
